pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage hold vector, two-step exception flush,
// consecutive-stall watchdog and total stall-cycle counter.
module pipe_ctrl #(
  parameter int STALL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        excp_i,
  input  logic [31:0] excp_addr_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH_WAIT,
    FLUSH
  } state_e;

  localparam logic [8:0] LIM = 9'(STALL_LIMIT);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] pc_q;
  logic        to_q;
  logic [31:0] cyc_q;

  logic        stall_act;
  logic [8:0]  cnt_inc;

  always_comb begin
    stall_o = 6'b000000;
    if (rst) begin
      case (state_q)
        FLUSH_WAIT: stall_o = 6'b111111;
        FLUSH:      stall_o = 6'b000000;
        default: begin
          if (excp_i)              stall_o = 6'b111111;
          else if (stallreq_mem_i) stall_o = 6'b011111;
          else if (stallreq_ex_i)  stall_o = 6'b001111;
          else if (stallreq_id_i)  stall_o = 6'b000111;
          else                     stall_o = 6'b000000;
        end
      endcase
    end
  end

  assign stall_act = |stall_o;
  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      pc_q    <= 32'h0;
      to_q    <= 1'b0;
      cyc_q   <= 32'h0;
    end else begin
      if (stall_act) begin
        cyc_q <= cyc_q + 32'd1;
        cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_inc[7:0];
        if (cnt_inc >= LIM) to_q <= 1'b1;
      end else begin
        cnt_q <= 8'd0;
      end
      case (state_q)
        RUN, STALL: begin
          if (excp_i) begin
            state_q <= FLUSH_WAIT;
            pc_q    <= excp_addr_i;
            cnt_q   <= 8'd0;
          end else begin
            state_q <= stall_act ? STALL : RUN;
          end
        end
        FLUSH_WAIT: state_q <= FLUSH;
        FLUSH:      state_q <= RUN;
        default:    state_q <= RUN;
      endcase
    end
  end

  // Gate with reset so a flush in progress never leaks out while held.
  assign flush_o         = rst && (state_q == FLUSH);
  assign new_pc_o        = pc_q;
  assign stall_timeout_o = to_q;
  assign stall_cycles_o  = cyc_q;

endmodule
